// File: rtl/loctag_adc_sampler.sv
// Serial-ADC capture engine for the LocTag detector chain: powers the LT5534,
// clocks MSB-first frames out of the ADC and hands each sample over valid/ready.
module loctag_adc_sampler #(
    parameter int CLK_DIV     = 8,
    parameter int FRAME_BITS  = 16,
    parameter int LEAD_BITS   = 3,
    parameter int DATA_BITS   = 12,
    parameter int IDLE_CYCLES = 32,
    parameter int EN_SETTLE   = 64,
    parameter int FCNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] threshold,
    input  logic                 sample_ready,
    input  logic                 adc_so,
    output logic                 adc_cs,
    output logic                 adc_sclk,
    output logic                 det_en,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 above,
    output logic                 overrun,
    output logic [FCNT_W-1:0]    frame_cnt,
    output logic [2:0]           fsm_state
);
    // Handshake: a sample transfers on any clk edge where sample_valid and
    // sample_ready are both high; sample_valid never drops without that transfer
    // except that a new frame may overwrite a pending sample (flagged by overrun).

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("loctag_adc_sampler: CLK_DIV must be >= 2");
    end
    if (LEAD_BITS + DATA_BITS > FRAME_BITS) begin : g_bad_frame
        $error("loctag_adc_sampler: LEAD_BITS + DATA_BITS exceeds FRAME_BITS");
    end

    localparam int MAX_A   = (EN_SETTLE > IDLE_CYCLES) ? EN_SETTLE : IDLE_CYCLES;
    localparam int CNT_MAX = (MAX_A > CLK_DIV) ? MAX_A : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);
    // Leading bits fall off the top of this register, so only the data field and
    // the trailing bits are kept.
    localparam int SH_W    = FRAME_BITS - LEAD_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        GAP    = 3'd2,
        CONV   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
    logic [SH_W-1:0]      shift, shift_d;
    logic                 cs_d, sclk_d, det_en_d;
    logic [DATA_BITS-1:0] sample_d;
    logic                 valid_d, above_d, overrun_d;
    logic [FCNT_W-1:0]    frame_cnt_d;
    logic [DATA_BITS-1:0] data_field;

    assign data_field = shift[SH_W-1 -: DATA_BITS];
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            adc_cs       <= 1'b1;
            adc_sclk     <= 1'b1;
            det_en       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            above        <= 1'b0;
            overrun      <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bit_cnt      <= bit_cnt_d;
            shift        <= shift_d;
            adc_cs       <= cs_d;
            adc_sclk     <= sclk_d;
            det_en       <= det_en_d;
            sample       <= sample_d;
            sample_valid <= valid_d;
            above        <= above_d;
            overrun      <= overrun_d;
            frame_cnt    <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_cnt_d   = bit_cnt;
        shift_d     = shift;
        cs_d        = adc_cs;
        sclk_d      = adc_sclk;
        det_en_d    = det_en;
        sample_d    = sample;
        valid_d     = sample_valid;
        above_d     = above;
        overrun_d   = overrun;
        frame_cnt_d = frame_cnt;

        if (sample_valid && sample_ready) begin
            valid_d = 1'b0;
        end

        if (!enable) begin
            // Abort: drop any partial frame but keep the last delivered sample.
            state_d   = IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
            cs_d      = 1'b1;
            sclk_d    = 1'b1;
            det_en_d  = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_d  = WARMUP;
                    det_en_d = 1'b1;
                    cnt_d    = '0;
                end
                WARMUP: begin
                    if (cnt == CNT_W'(EN_SETTLE - 1)) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(IDLE_CYCLES - 1)) begin
                        state_d   = CONV;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        cs_d      = 1'b0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                CONV: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt_d  = '0;
                        sclk_d = ~adc_sclk;
                        // sclk low now means this edge drives it high: capture.
                        if (!adc_sclk) begin
                            shift_d   = {shift[SH_W-2:0], adc_so};
                            bit_cnt_d = bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                                state_d = DONE;
                                cs_d    = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    sample_d    = data_field;
                    above_d     = (data_field >= threshold);
                    valid_d     = 1'b1;
                    frame_cnt_d = frame_cnt + FCNT_W'(1);
                    if (sample_valid && !sample_ready) begin
                        overrun_d = 1'b1;
                    end
                    state_d   = GAP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end
endmodule
